// File: rtl/multicycle_comparator_controller.sv
// Multi-cycle signed/unsigned magnitude comparator, CHUNK bits per cycle from the MSB down,
// with a start/done handshake. Optional macro EARLY_EXIT_EN ends the scan at the first differing chunk.
module multicycle_comparator_controller #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [1:0]       code
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]    LAST_IDX  = CW'(N - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             found_q, found_d;
    logic             rec_lt_q, rec_lt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             chunk_ne;
    logic             chunk_lt;
    logic             res_diff;
    logic             res_lt;
    logic             accept;
    logic             finish;
    logic             early;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign a_cmp    = signed_q ? (a_q ^ SIGN_MASK) : a_q;
    assign b_cmp    = signed_q ? (b_q ^ SIGN_MASK) : b_q;
    assign chunk_a  = a_cmp[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b  = b_cmp[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_ne = (chunk_a != chunk_b);
    assign chunk_lt = (chunk_a < chunk_b);

    // The most significant differing chunk decides; later chunks never override it.
    assign res_diff = found_q | chunk_ne;
    assign res_lt   = found_q ? rec_lt_q : chunk_lt;

    assign accept = start && (state_q != S_SCAN);

`ifdef EARLY_EXIT_EN
    assign early = !found_q && chunk_ne;
`else
    assign early = 1'b0;
`endif

    assign finish = (state_q == S_SCAN) && ((idx_q == '0) || early);

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        found_d  = found_q;
        rec_lt_d = rec_lt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SCAN: begin
                if (!found_q && chunk_ne) begin
                    found_d  = 1'b1;
                    rec_lt_d = chunk_lt;
                end
                if (finish) begin
                    state_d = S_DONE;
                    lt_d    = res_diff & res_lt;
                    gt_d    = res_diff & ~res_lt;
                    eq_d    = ~res_diff;
                end else begin
                    idx_d = idx_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept overrides the IDLE/DONE defaults above, giving back-to-back starts from DONE.
        if (accept) begin
            state_d  = S_SCAN;
            idx_d    = LAST_IDX;
            a_d      = a;
            b_d      = b;
            signed_d = is_signed;
            found_d  = 1'b0;
            rec_lt_d = 1'b0;
            lt_d     = 1'b0;
            eq_d     = 1'b0;
            gt_d     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            found_q  <= 1'b0;
            rec_lt_q <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            found_q  <= found_d;
            rec_lt_q <= rec_lt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
        end
    end

    assign busy = (state_q == S_SCAN);
    assign done = (state_q == S_DONE);
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign code = {lt_q | gt_q, eq_q | gt_q};

endmodule

// File: tb/tb_multicycle_comparator_controller.sv
// Scoreboard bench for multicycle_comparator_controller (WIDTH=32, CHUNK=4).
// Expected results are queued at each accepted start and compared on every done pulse.
module tb_multicycle_comparator_controller;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct {
        logic lt;
        logic eq;
        logic gt;
        int   lat;
        int   acc_edge;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [1:0]       code;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_comparator_controller #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt),
        .code     (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef EARLY_EXIT_EN
        logic [WIDTH-1:0] d;
        int hi;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < WIDTH; i++) if (d[i]) hi = i;
        if (hi < 0) return N + 1;
        return 1 + (N - hi / CHUNK);
`else
        return N + 1;
`endif
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns at the next negedge.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic s, input bit expect_result);
        exp_t e;
        logic is_lt;
        is_lt = s ? ($signed(x) < $signed(y)) : (x < y);
        e.eq  = (x == y);
        e.lt  = is_lt;
        e.gt  = !is_lt && (x != y);
        e.lat = exp_latency(x, y);
        e.acc_edge = edge_cnt + 1;
        a = x;
        b = y;
        is_signed = s;
        start = 1'b1;
        if (expect_result) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lt", 64'(lt), 64'(e.lt));
                check("eq", 64'(eq), 64'(e.eq));
                check("gt", 64'(gt), 64'(e.gt));
                check("code", 64'(code), e.lt ? 64'd2 : (e.eq ? 64'd1 : 64'd3));
                check("busy_in_done", 64'(busy), 64'd0);
                check("latency", 64'(edge_cnt - e.acc_edge + 1), 64'(e.lat));
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flags", 64'({lt, eq, gt}), 64'd0);
        check("rst_code", 64'(code), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic patterns and boundaries
        issue(32'd5, 32'd9, 1'b0, 1'b1);
        wait_idle("t1");
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_idle("t2u");
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1);
        wait_idle("t2s");
        issue(32'hFFFFFFFF, 32'd1, 1'b1, 1'b1);
        wait_idle("t3s");
        issue(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        wait_idle("t3u");
        issue(32'h80000000, 32'd0, 1'b0, 1'b1);
        wait_idle("t4");
        issue(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
        wait_idle("smax_vs_smin");
        repeat (3) @(negedge clk);
        check("hold_after_done", 64'(code), 64'd3);

        // Start and operand changes mid-SCAN are ignored
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        check("busy_after_accept", 64'(busy), 64'd1);
        check("cleared_on_accept", 64'(code), 64'd0);
        repeat (2) @(negedge clk);
        a = 32'd1;
        b = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t5_ignore");

        // Reset mid-SCAN discards the in-flight compare
        issue(32'd1, 32'd2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_flags", 64'({lt, eq, gt, done}), 64'd0);
        check("midrst_code", 64'(code), 64'd0);
        repeat (N + 3) @(negedge clk);
        issue(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_idle("t5_fresh");

        // Back-to-back accept in the done cycle
        issue(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_done_seen", 64'(done), 64'd1);
        check("t6_hold_in_done", 64'(code), 64'd3);
        issue(32'd3, 32'd3, 1'b0, 1'b1);
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_cleared", 64'(code), 64'd0);
        wait_idle("t6");

        // A handful of random operands in both modes
        for (int i = 0; i < 12; i++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            x = $urandom;
            y = (i % 3 == 0) ? x : $urandom;
            if (i % 4 == 1) y = x ^ (32'h1 << $urandom_range(31, 0));
            issue(x, y, 1'(i % 2), 1'b1);
            wait_idle("rand");
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
